// File: rtl/fpdlink_tx_packer.sv
// FPD-Link I transmit pixel packer: small pixel FIFO, startup/prime/run sequencing, and
// mapping of 24-bit RGB plus syncs onto four 7-bit data-lane words and a fixed clock-lane word.
module fpdlink_tx_packer #(
    parameter int unsigned FIFO_DEPTH     = 4,
    parameter int unsigned PRIME_LEVEL    = 2,
    parameter int unsigned STARTUP_CYCLES = 64,
    parameter string       MAPPING        = "VESA",
    parameter logic [6:0]  CLK_PATTERN    = 7'b1100011
) (
    input  logic        gclk,
    input  logic        rst,
    input  logic        tx_en,
    input  logic        pix_valid,
    output logic        pix_ready,
    input  logic [23:0] pix_data,
    input  logic        pix_hs,
    input  logic        pix_vs,
    input  logic        pix_de,
    output logic [6:0]  lane_clk,
    output logic [27:0] lane_data,
    output logic        running,
    output logic        underflow,
    input  logic        clr_underflow,
    output logic [15:0] underflow_cnt
);
    localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW = PW + 1;
    localparam int unsigned SW = (STARTUP_CYCLES > 0) ? $clog2(STARTUP_CYCLES + 1) : 1;
    localparam bit          JEIDA = (MAPPING == "JEIDA");

    typedef enum logic [1:0] {S_IDLE, S_PRIME, S_RUN} state_t;

    typedef struct packed {
        logic        hs;
        logic        vs;
        logic        de;
        logic [23:0] rgb;
    } pix_t;

    state_t          state, state_nxt;
    pix_t            mem [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr, rd_ptr;
    logic [CW-1:0]   count;
    logic [SW-1:0]   su_cnt;
    logic            last_hs, last_vs;
    logic            startup_done, push, pop, uf_hit, flush;
    pix_t            in_pix, head, blank;

    // Lane bit mapping; lane3 bit6 is always 0
    function automatic logic [27:0] map_word(input pix_t p);
        logic [7:0] r, g, b;
        logic [6:0] l0, l1, l2, l3;
        r = p.rgb[23:16];
        g = p.rgb[15:8];
        b = p.rgb[7:0];
        if (JEIDA) begin
            l0 = {g[2], r[7:2]};
            l1 = {b[3:2], g[7:3]};
            l2 = {p.de, p.vs, p.hs, b[7:4]};
            l3 = {1'b0, b[1:0], g[1:0], r[1:0]};
        end else begin
            l0 = {g[0], r[5:0]};
            l1 = {b[1:0], g[5:1]};
            l2 = {p.de, p.vs, p.hs, b[5:2]};
            l3 = {1'b0, b[7:6], g[7:6], r[7:6]};
        end
        return {l3, l2, l1, l0};
    endfunction

    assign pix_ready    = (state != S_IDLE) && (count < CW'(FIFO_DEPTH));
    assign startup_done = (su_cnt == SW'(STARTUP_CYCLES));

    always_ff @(posedge gclk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (tx_en && startup_done) state_nxt = S_PRIME;
            S_PRIME: begin
                if (!tx_en)                          state_nxt = S_IDLE;
                else if (count >= CW'(PRIME_LEVEL))  state_nxt = S_RUN;
            end
            S_RUN:   if (!tx_en) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
        push     = pix_valid && pix_ready && tx_en;
        pop      = (state == S_RUN) && tx_en && (count != '0);
        uf_hit   = (state == S_RUN) && tx_en && (count == '0);
        flush    = (state_nxt == S_IDLE);
        in_pix   = '{hs: pix_hs, vs: pix_vs, de: pix_de, rgb: pix_data};
        head     = mem[rd_ptr];
        // Blank keeps the last popped syncs, except when heading back to IDLE
        blank    = '0;
        blank.hs = last_hs & ~flush;
        blank.vs = last_vs & ~flush;
    end

    always_ff @(posedge gclk) begin
        if (push && !flush) mem[wr_ptr] <= in_pix;
    end

    always_ff @(posedge gclk or posedge rst) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            last_hs <= 1'b0;
            last_vs <= 1'b0;
        end else if (flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            last_hs <= 1'b0;
            last_vs <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop) begin
                rd_ptr  <= rd_ptr + PW'(1);
                last_hs <= head.hs;
                last_vs <= head.vs;
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // Output words, status and startup timer
    always_ff @(posedge gclk or posedge rst) begin
        if (rst) begin
            lane_clk      <= CLK_PATTERN;
            lane_data     <= '0;
            running       <= 1'b0;
            underflow     <= 1'b0;
            underflow_cnt <= '0;
            su_cnt        <= '0;
        end else begin
            lane_clk  <= CLK_PATTERN;
            lane_data <= pop ? map_word(head) : map_word(blank);
            running   <= (state_nxt == S_RUN);
            if (!startup_done) su_cnt <= su_cnt + SW'(1);
            if (clr_underflow) begin
                underflow     <= 1'b0;
                underflow_cnt <= '0;
            end else if (uf_hit) begin
                underflow <= 1'b1;
                if (underflow_cnt != 16'hFFFF) underflow_cnt <= underflow_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_fpdlink_tx_packer.sv
// Bench for fpdlink_tx_packer: cycle reference model with a pixel queue for a VESA
// instance, mapping vector table, directed corner sequences, and a JEIDA/full-prime instance.
module tb_fpdlink_tx_packer;
    localparam logic [6:0] CLKPAT = 7'b1100011;
    localparam int D = 4;
    localparam int P = 2;
    localparam int S = 64;

    logic gclk = 1'b0;
    always #5 gclk = ~gclk;

    logic        rst;
    logic        tx_en, pix_valid, pix_hs, pix_vs, pix_de, clr_underflow;
    logic [23:0] pix_data;
    logic        pix_ready, running, underflow;
    logic [6:0]  lane_clk;
    logic [27:0] lane_data;
    logic [15:0] underflow_cnt;

    logic        j_tx_en, j_pix_valid, j_pix_de;
    logic [23:0] j_pix_data;
    logic        j_pix_ready, j_running, j_underflow;
    logic [6:0]  j_lane_clk;
    logic [27:0] j_lane_data;
    logic [15:0] j_underflow_cnt;

    fpdlink_tx_packer u_dut (
        .gclk(gclk), .rst(rst), .tx_en(tx_en), .pix_valid(pix_valid), .pix_ready(pix_ready),
        .pix_data(pix_data), .pix_hs(pix_hs), .pix_vs(pix_vs), .pix_de(pix_de),
        .lane_clk(lane_clk), .lane_data(lane_data), .running(running), .underflow(underflow),
        .clr_underflow(clr_underflow), .underflow_cnt(underflow_cnt)
    );

    fpdlink_tx_packer #(.FIFO_DEPTH(4), .PRIME_LEVEL(4), .MAPPING("JEIDA")) u_dut_j (
        .gclk(gclk), .rst(rst), .tx_en(j_tx_en), .pix_valid(j_pix_valid), .pix_ready(j_pix_ready),
        .pix_data(j_pix_data), .pix_hs(1'b0), .pix_vs(1'b0), .pix_de(j_pix_de),
        .lane_clk(j_lane_clk), .lane_data(j_lane_data), .running(j_running), .underflow(j_underflow),
        .clr_underflow(1'b0), .underflow_cnt(j_underflow_cnt)
    );

    int n_vec = 0;
    int n_bad = 0;

    typedef struct packed {
        logic [23:0] rgb;
        logic        hs;
        logic        vs;
        logic        de;
    } px_t;

    typedef struct packed {
        logic [23:0] rgb;
        logic        hs;
        logic        vs;
        logic        de;
        logic [27:0] exp_word;
    } tv_t;

    // Reference model state: 0 idle, 1 prime, 2 run
    int          m_phase, m_su, m_ucnt;
    px_t         m_q[$];
    logic [27:0] m_lane;
    bit          m_uf, m_lhs, m_lvs;

    function automatic logic [27:0] vesa_ref(input logic [23:0] rgb, input bit hs, vs, de);
        int unsigned r, g, b, l0, l1, l2, l3;
        r  = rgb[23:16]; g = rgb[15:8]; b = rgb[7:0];
        l0 = (r % 64) + (g % 2) * 64;
        l1 = (g / 2) % 32 + (b % 4) * 32;
        l2 = (b / 4) % 16 + 16 * hs + 32 * vs + 64 * de;
        l3 = (r / 64) + (g / 64) * 4 + (b / 64) * 16;
        return 28'(l0 + l1 * 128 + l2 * 16384 + l3 * 2097152);
    endfunction

    function automatic logic [27:0] jeida_ref(input logic [23:0] rgb, input bit hs, vs, de);
        int unsigned r, g, b, l0, l1, l2, l3;
        r  = rgb[23:16]; g = rgb[15:8]; b = rgb[7:0];
        l0 = (r / 4) + ((g / 4) % 2) * 64;
        l1 = (g / 8) + ((b / 4) % 4) * 32;
        l2 = (b / 16) + 16 * hs + 32 * vs + 64 * de;
        l3 = (r % 4) + (g % 4) * 4 + (b % 4) * 16;
        return 28'(l0 + l1 * 128 + l2 * 16384 + l3 * 2097152);
    endfunction

    function automatic bit model_ready();
        return (m_phase != 0) && (m_q.size() < D);
    endfunction

    task automatic model_reset();
        m_phase = 0; m_su = 0; m_ucnt = 0; m_q.delete();
        m_lane = '0; m_uf = 0; m_lhs = 0; m_lvs = 0;
    endtask

    task automatic model_step(input bit en, v, input logic [23:0] d, input bit hs, vs, de, clr);
        bit  psh, pp, uf;
        int  np;
        px_t p;
        psh = v && model_ready() && en;
        pp  = (m_phase == 2) && en && (m_q.size() > 0);
        uf  = (m_phase == 2) && en && (m_q.size() == 0);
        np  = m_phase;
        if (m_phase == 0) begin
            if (en && m_su == S) np = 1;
        end else if (!en) np = 0;
        else if (m_phase == 1 && m_q.size() >= P) np = 2;
        if (pp) begin
            p = m_q.pop_front();
            m_lane = vesa_ref(p.rgb, p.hs, p.vs, p.de);
            m_lhs = p.hs; m_lvs = p.vs;
        end else begin
            m_lane = vesa_ref(24'h0, (np == 0) ? 1'b0 : m_lhs, (np == 0) ? 1'b0 : m_lvs, 1'b0);
        end
        if (np == 0) begin
            m_q.delete(); m_lhs = 0; m_lvs = 0;
        end else if (psh) begin
            m_q.push_back('{rgb: d, hs: hs, vs: vs, de: de});
        end
        if (clr) begin
            m_uf = 0; m_ucnt = 0;
        end else if (uf) begin
            m_uf = 1;
            if (m_ucnt < 65535) m_ucnt++;
        end
        if (m_su < S) m_su++;
        m_phase = np;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all();
        chk("lane_clk", 32'(lane_clk), 32'(CLKPAT));
        chk("lane_data", 32'(lane_data), 32'(m_lane));
        chk("pix_ready", 32'(pix_ready), 32'(model_ready()));
        chk("running", 32'(running), 32'(m_phase == 2));
        chk("underflow", 32'(underflow), 32'(m_uf));
        chk("underflow_cnt", 32'(underflow_cnt), 32'(m_ucnt));
    endtask

    // Called at a negedge: check, drive, clock once, advance model, return at next negedge
    task automatic cycle(input bit en, v, input logic [23:0] d, input bit hs, vs, de, clr);
        check_all();
        tx_en = en; pix_valid = v; pix_data = d; pix_hs = hs; pix_vs = vs; pix_de = de;
        clr_underflow = clr;
        @(posedge gclk);
        model_step(en, v, d, hs, vs, de, clr);
        @(negedge gclk);
    endtask

    task automatic idle();
        cycle(1'b1, 1'b0, 24'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic startup_run(output int first);
        first = -1;
        for (int k = 1; k <= 200; k++) begin
            idle();
            if (pix_ready) begin
                first = k;
                break;
            end
        end
    endtask

    task automatic push_until_running(input string name);
        for (int k = 0; k < 50; k++) begin
            if (running) break;
            cycle(1'b1, 1'b1, 24'($urandom), 1'b0, 1'b0, 1'b1, 1'b0);
        end
        chk(name, 32'(running), 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tv_t         tv[5];
        px_t         jp[4];
        int          first, acc;
        bit          r;

        tv[0] = '{rgb: 24'hFF0000, hs: 0, vs: 0, de: 1, exp_word: 28'h070003F};
        tv[1] = '{rgb: 24'h00FF00, hs: 0, vs: 0, de: 0, exp_word: 28'h1800FC0};
        tv[2] = '{rgb: 24'h0000FF, hs: 1, vs: 1, de: 1, exp_word: 28'h61FF000};
        tv[3] = '{rgb: 24'h000000, hs: 0, vs: 1, de: 0, exp_word: 28'h0080000};
        tv[4] = '{rgb: 24'hA53C0F, hs: 0, vs: 0, de: 1, exp_word: 28'h050FF25};
        jp[0] = '{rgb: 24'h000400, hs: 0, vs: 0, de: 1};
        jp[1] = '{rgb: 24'h123456, hs: 0, vs: 0, de: 1};
        jp[2] = '{rgb: 24'hFEDCBA, hs: 0, vs: 0, de: 1};
        jp[3] = '{rgb: 24'h80FF01, hs: 0, vs: 0, de: 1};

        rst = 1'b1;
        tx_en = 0; pix_valid = 0; pix_data = '0; pix_hs = 0; pix_vs = 0; pix_de = 0; clr_underflow = 0;
        j_tx_en = 0; j_pix_valid = 0; j_pix_data = '0; j_pix_de = 0;
        model_reset();
        @(negedge gclk); @(negedge gclk);
        check_all();
        chk("j_reset_lane", 32'(j_lane_data), 32'h0);
        chk("j_reset_clk", 32'(j_lane_clk), 32'(CLKPAT));
        rst = 1'b0;

        // Startup wait: 64 cycles not ready, PRIME on cycle 65
        startup_run(first);
        chk("startup_len", 32'(first), 32'd65);

        // Prime with two pixels, first RUN word is the red pixel
        cycle(1, 1, 24'hFF0000, 0, 0, 1, 0);
        cycle(1, 1, 24'h00FF00, 0, 0, 0, 0);
        idle();
        chk("t2_running", 32'(running), 32'd1);
        idle();
        chk("t2_lane0", 32'(lane_data[6:0]), 32'h3F);
        chk("t2_lane3", 32'(lane_data[27:21]), 32'h03);

        // Mapping table, one pixel then one gap each
        for (int i = 0; i < 5; i++) begin
            cycle(1, 1, tv[i].rgb, tv[i].hs, tv[i].vs, tv[i].de, 0);
            idle();
            chk($sformatf("table_%0d", i), 32'(lane_data), 32'(tv[i].exp_word));
        end

        // Underflow after an HS pixel, with clear colliding with an underflow
        cycle(1, 1, 24'h112233, 1, 0, 1, 1);
        idle();
        for (int k = 0; k < 3; k++) begin
            idle();
            chk($sformatf("uf_blank_%0d", k), 32'(lane_data), 32'h0040000);
        end
        chk("uf_flag", 32'(underflow), 32'd1);
        chk("uf_cnt3", 32'(underflow_cnt), 32'd3);

        // Randomized traffic against the model
        for (int k = 0; k < 1500; k++) begin
            cycle(($urandom % 64) != 0, ($urandom % 4) != 0, 24'($urandom),
                  ($urandom % 8) == 0, ($urandom % 16) == 0, ($urandom % 2) == 0,
                  ($urandom % 40) == 0);
        end

        // tx_en drop mid-stream, quick re-prime, then async reset mid-RUN
        push_until_running("t6_run1");
        for (int k = 0; k < 3; k++) cycle(0, 1, 24'($urandom), 1, 1, 1, 0);
        chk("t6_idle_run", 32'(running), 32'd0);
        chk("t6_idle_ready", 32'(pix_ready), 32'd0);
        chk("t6_idle_blank", 32'(lane_data), 32'h0);
        idle();
        chk("t6_reprime", 32'(pix_ready), 32'd1);
        push_until_running("t6_run2");
        cycle(1, 1, 24'h5A5A5A, 0, 0, 1, 0);
        rst = 1'b1;
        model_reset();
        #1;
        check_all();
        @(posedge gclk);
        @(negedge gclk);
        check_all();
        rst = 1'b0;
        startup_run(first);
        chk("t6_startup_len", 32'(first), 32'd65);

        // JEIDA instance with PRIME_LEVEL == FIFO_DEPTH and the sink stalled
        j_tx_en = 1'b1;
        acc = 0;
        for (int k = 0; k < 30 && acc < 4; k++) begin
            r = j_pix_ready;
            j_pix_valid = 1'b1;
            j_pix_data  = jp[acc].rgb;
            j_pix_de    = jp[acc].de;
            @(posedge gclk);
            if (r) acc++;
            @(negedge gclk);
        end
        chk("j_accepts", 32'(acc), 32'd4);
        chk("j_ready_full", 32'(j_pix_ready), 32'd0);
        j_pix_valid = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (j_running) break;
            @(negedge gclk);
        end
        chk("j_running", 32'(j_running), 32'd1);
        for (int i = 0; i < 4; i++) begin
            @(negedge gclk);
            chk($sformatf("j_order_%0d", i), 32'(j_lane_data),
                32'(jeida_ref(jp[i].rgb, jp[i].hs, jp[i].vs, jp[i].de)));
            if (i == 0) begin
                chk("j_lane0", 32'(j_lane_data[6:0]), 32'h40);
                chk("j_de_bit", 32'(j_lane_data[20]), 32'd1);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
